// File: rtl/core_if_stage.sv
// RV32I fetch stage: owns PC, issues ibus word reads, queues {pc,instr} for decode; CORE_IF_JAL_PREDICT_EN enables JAL prediction.
// Latency: gnt in cycle N, rvalid in N+1 -> o_valid in N+2; sustains one instruction per cycle on a 1-cycle bus.
// Backpressure: i_id_ready=0 holds the queue head; issue stops once in-flight + queued words reach FQ_DEPTH.
module core_if_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int          FQ_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_gnt,
    input  logic        i_ibus_rvalid,
    input  logic [31:0] i_ibus_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_id_ready,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_pred_taken
);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   occ_t;
    typedef logic [PW-1:0] ptr_t;
    localparam occ_t        LIM  = occ_t'(FQ_DEPTH);
    localparam ptr_t        LAST = ptr_t'(FQ_DEPTH - 1);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct packed {
        logic        pred;
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef enum logic {BOOT, RUN} state_t;
    state_t state, state_nxt;

    logic [31:0] pc;
    logic [31:0] tag_mem [FQ_DEPTH];
    ptr_t        tag_wp, tag_rp;
    cnt_t        inflight, discard;
    fq_entry_t   fq_mem [FQ_DEPTH];
    ptr_t        fq_wp, fq_rp;
    cnt_t        fq_count;
    fq_entry_t   head;

    logic        gnt, drop, push, pop, jal_hit;
    logic [31:0] tag_pc, jal_target;
    occ_t        occ;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head    = fq_mem[fq_rp];
    assign tag_pc  = tag_mem[tag_rp];
    assign o_valid = (fq_count != '0);
    assign o_instr = o_valid ? head.instr : NOP;
    assign o_pc    = o_valid ? head.pc : 32'h0;
    assign o_pred_taken = o_valid && head.pred;
    assign o_ibus_addr  = pc;

    assign pop  = o_valid && i_id_ready && !i_redirect;
    assign gnt  = o_ibus_req && i_ibus_gnt;
    assign drop = i_ibus_rvalid && (i_redirect || (discard != '0));
    assign push = i_ibus_rvalid && !drop;
    // The slot freed by this cycle's pop is credited so a 1-cycle bus streams back-to-back.
    assign occ  = occ_t'(inflight) + occ_t'(fq_count) - occ_t'(pop);

    assign jal_target = tag_pc + {{11{i_ibus_rdata[31]}}, i_ibus_rdata[31], i_ibus_rdata[19:12],
                                  i_ibus_rdata[20], i_ibus_rdata[30:21], 1'b0};
`ifdef CORE_IF_JAL_PREDICT_EN
    assign jal_hit = push && (i_ibus_rdata[6:0] == 7'b1101111);
`else
    assign jal_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        o_ibus_req = 1'b0;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     o_ibus_req = (occ < LIM) && !i_redirect;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= BOOT_ADDR;
            tag_wp   <= '0;
            tag_rp   <= '0;
            inflight <= '0;
            discard  <= '0;
            fq_wp    <= '0;
            fq_rp    <= '0;
            fq_count <= '0;
        end else begin
            state <= state_nxt;
            // Tags track every outstanding grant, including ones whose data will be dropped.
            if (gnt)           tag_wp <= ptr_inc(tag_wp);
            if (i_ibus_rvalid) tag_rp <= ptr_inc(tag_rp);
            inflight <= inflight + cnt_t'(gnt) - cnt_t'(i_ibus_rvalid);
            if (i_redirect) begin
                pc       <= i_redirect_pc & ~32'h3;
                discard  <= inflight - cnt_t'(i_ibus_rvalid);
                fq_wp    <= '0;
                fq_rp    <= '0;
                fq_count <= '0;
            end else begin
                if (jal_hit) begin
                    // Everything granted after the JAL, including this cycle's grant, is wrong-path.
                    pc      <= jal_target;
                    discard <= inflight + cnt_t'(gnt) - cnt_t'(1);
                end else begin
                    if (gnt)  pc      <= pc + 32'd4;
                    if (drop) discard <= discard - 1'b1;
                end
                if (push) fq_wp <= ptr_inc(fq_wp);
                if (pop)  fq_rp <= ptr_inc(fq_rp);
                if (push && !pop)      fq_count <= fq_count + 1'b1;
                else if (pop && !push) fq_count <= fq_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt)  tag_mem[tag_wp] <= pc;
        if (push) fq_mem[fq_wp]   <= '{pred: jal_hit, pc: tag_pc, instr: i_ibus_rdata};
    end
endmodule

// File: tb/tb_core_if_stage.sv
`timescale 1ns/1ps
module tb_core_if_stage;
    localparam logic [31:0] BOOT  = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef CORE_IF_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_ibus_req;
    logic [31:0] o_ibus_addr;
    logic        i_ibus_gnt;
    logic        i_ibus_rvalid;
    logic [31:0] i_ibus_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_id_ready;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_pred_taken;

    always #5 clk = ~clk;

    core_if_stage #(.BOOT_ADDR(BOOT), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .o_ibus_req(o_ibus_req), .o_ibus_addr(o_ibus_addr), .i_ibus_gnt(i_ibus_gnt),
        .i_ibus_rvalid(i_ibus_rvalid), .i_ibus_rdata(i_ibus_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_id_ready(i_id_ready),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pred_taken(o_pred_taken)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program memory: every word is a non-JAL pattern except a JAL (+8) planted at 0x40.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h0080_006F;
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic is_jal(input logic [31:0] w);
        return w[6:0] == 7'b1101111;
    endfunction

    function automatic logic [31:0] jal_off(input logic [31:0] w);
        logic [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {{11{imm[20]}}, imm};
    endfunction

    // Bus model: grants everything, returns words in order after 'lat' cycles.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    int          lat = 1;
    int          cyc = 0;
    int          n_gnt = 0;
    logic [31:0] cur_raddr = 32'h0;

    initial begin
        i_ibus_gnt    = 1'b1;
        i_ibus_rvalid = 1'b0;
        i_ibus_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && o_ibus_req && i_ibus_gnt) begin
                pend.push_back('{addr: o_ibus_addr, due: cyc + lat});
                n_gnt++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                pend.delete();
                i_ibus_rvalid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                cur_raddr     = pend[0].addr;
                i_ibus_rdata  = mem_word(pend[0].addr);
                i_ibus_rvalid = 1'b1;
                void'(pend.pop_front());
            end else begin
                i_ibus_rvalid = 1'b0;
                i_ibus_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference: decode must see the architectural PC stream, one PC after another.
    logic [31:0] exp_pc = BOOT;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          n_acc = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc     = BOOT;
            prev_stall = 1'b0;
        end else begin
            chk("outstanding_bound", 32'(pend.size() <= DEPTH), 32'd1);
            if (o_ibus_req) chk("addr_align", {30'b0, o_ibus_addr[1:0]}, 32'd0);
            if (i_redirect) chk("no_req_on_redirect", {31'b0, o_ibus_req}, 32'd0);
            if (!o_valid) chk("empty_nop", o_instr, NOP);
            if (prev_stall) begin
                chk("stall_valid", {31'b0, o_valid}, 32'd1);
                chk("stall_pc", o_pc, prev_pc);
                chk("stall_instr", o_instr, prev_instr);
            end
            if (i_redirect) begin
                exp_pc = i_redirect_pc & ~32'h3;
            end else if (o_valid && i_id_ready) begin
                chk("dec_pc", o_pc, exp_pc);
                chk("dec_instr", o_instr, mem_word(exp_pc));
                chk("dec_pred", {31'b0, o_pred_taken}, {31'b0, JAL_EN && is_jal(mem_word(exp_pc))});
                if (JAL_EN && is_jal(mem_word(exp_pc))) exp_pc = exp_pc + jal_off(mem_word(exp_pc));
                else                                     exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            prev_stall = o_valid && !i_id_ready && !i_redirect;
            prev_pc    = o_pc;
            prev_instr = o_instr;
        end
    end

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!o_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!o_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: o_valid still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        @(posedge clk); #1;
        i_redirect    = 1'b0;
    endtask

    initial begin
        int          g0, a0, k;
        logic        found;
        logic [7:0]  pat;
        pat           = 8'b1011_0110;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_id_ready    = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", {31'b0, o_ibus_req}, 32'd0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_pred", {31'b0, o_pred_taken}, 32'd0);
        chk("rst_addr", o_ibus_addr, BOOT);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: boot stream at full rate
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_valid0", {31'b0, o_valid}, 32'd1);
        chk("t1_pc0", o_pc, 32'h0000_0100);
        @(negedge clk);
        chk("t1_pc1", o_pc, 32'h0000_0104);
        @(negedge clk);
        chk("t1_pc2", o_pc, 32'h0000_0108);
        chk("t1_instr2", o_instr, 32'h5A5A_0108);

        // 2: decode stall for 5 cycles
        @(posedge clk); #1;
        i_id_ready = 1'b0;
        g0 = n_gnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t2_req_stopped", {31'b0, o_ibus_req}, 32'd0);
        chk("t2_grants_bounded", 32'(n_gnt - g0 <= DEPTH), 32'd1);
        @(posedge clk); #1;
        i_id_ready = 1'b1;
        repeat (6) @(posedge clk);

        // 3: redirect to a misaligned target with responses in flight
        lat = 2;
        repeat (6) @(posedge clk);
        redirect_to(32'h0000_0203);
        wait_valid("t3_wait", 20);
        chk("t3_first_pc", o_pc, 32'h0000_0200);
        lat = 1;
        repeat (6) @(posedge clk);

        // 4: PC wraps past the top of the address space
        redirect_to(32'hFFFF_FFF8);
        k = 0;
        found = 1'b0;
        while (k < 40 && !found) begin
            @(negedge clk);
            found = o_ibus_req && i_ibus_gnt && (o_ibus_addr == 32'hFFFF_FFFC);
            k++;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL t4_wait: no grant at FFFFFFFC within 40 cycles");
        end else begin
            @(negedge clk);
            chk("t4_wrap_addr", o_ibus_addr, 32'h0000_0000);
        end
        repeat (8) @(posedge clk);

        // 5: slow bus with intermittent stalls and a redirect in the middle
        lat = 3;
        a0 = n_acc;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk); #1;
            i_id_ready = pat[i % 8];
            i_redirect = (i == 24);
            i_redirect_pc = 32'h0000_0300;
        end
        @(posedge clk); #1;
        i_redirect = 1'b0;
        i_id_ready = 1'b1;
        chk("t5_progress", 32'(n_acc - a0 >= 8), 32'd1);
        lat = 1;
        repeat (10) @(posedge clk);

        // 6: JAL at 0x40 (predicted only when the feature is built in)
        redirect_to(32'h0000_0040);
        wait_valid("t6_wait0", 20);
        chk("t6_pc_jal", o_pc, 32'h0000_0040);
        chk("t6_pred", {31'b0, o_pred_taken}, {31'b0, JAL_EN});
        wait_valid("t6_wait1", 20);
        chk("t6_next_pc", o_pc, JAL_EN ? 32'h0000_0048 : 32'h0000_0044);
        repeat (4) @(posedge clk);
        redirect_to(32'h0000_0040);
        k = 0;
        found = 1'b0;
        while (k < 20 && !found) begin
            @(posedge clk); #2;
            found = i_ibus_rvalid && (cur_raddr == 32'h0000_0040);
            k++;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL t6_wait2: no response for 0x40 within 20 cycles");
        end else begin
            i_redirect    = 1'b1;
            i_redirect_pc = 32'h0000_0080;
            @(posedge clk); #1;
            i_redirect    = 1'b0;
            wait_valid("t6_wait3", 20);
            chk("t6_ext_wins", o_pc, 32'h0000_0080);
        end
        repeat (6) @(posedge clk);

        // Reset in the middle of traffic
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst2_valid", {31'b0, o_valid}, 32'd0);
        chk("rst2_req", {31'b0, o_ibus_req}, 32'd0);
        chk("rst2_addr", o_ibus_addr, BOOT);
        chk("rst2_instr", o_instr, NOP);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        wait_valid("rst2_wait", 20);
        chk("rst2_first_pc", o_pc, BOOT);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
